// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: synchronises the bus, frames 11-bit packets, folds
// E0/F0 prefixes into make/break events and queues them in a show-ahead FIFO.
module ps2_kbd_event_rx #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          frame_err,
  output logic [ERR_W-1:0]              err_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------- synchronisers ----------------
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   clk_s, dat_s, strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign strobe = clk_prev & ~clk_s;

  // ---------------- frame receiver ----------------
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          rx_valid;
  logic [7:0]    rx_code;
  logic          frame_ok;

  // Stop bit is taken straight from the synchroniser on the final strobe.
  assign frame_ok = ~shreg[0] & dat_s & (^shreg[9:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      rx_valid  <= 1'b0;
      rx_code   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (strobe) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            rx_valid <= 1'b1;
            rx_code  <= shreg[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shreg[bit_cnt] <= dat_s;
          bit_cnt        <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (frame_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  // ---------------- prefix decoder ----------------
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} dec_state_t;
  dec_state_t state, state_nx;
  logic       push;
  logic [9:0] push_data;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rx_valid) begin
      case (rx_code)
        8'hE0:   if (state == S_IDLE) state_nx = S_EXT;
        8'hF0: begin
          if (state == S_IDLE)     state_nx = S_BRK;
          else if (state == S_EXT) state_nx = S_EXT_BRK;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (rx_valid && (rx_code != 8'hE0) && (rx_code != 8'hF0)) begin
      push      = 1'b1;
      push_data = {(state == S_EXT) || (state == S_EXT_BRK),
                   (state == S_BRK) || (state == S_EXT_BRK),
                   rx_code};
    end
  end

  // ---------------- event FIFO ----------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, wr_en;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = evt_ready & ~empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  assign evt_valid                   = ~empty;
  assign {evt_ext, evt_brk, evt_code} = mem[rd_ptr];
  assign fifo_level                  = count;

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// Randomised scoreboard bench for ps2_kbd_event_rx; stimulus pushes expected
// events, an independent monitor pops and compares on every accepted handshake.
module tb_ps2_kbd_event_rx;
  localparam int HALF   = 10;
  localparam int TO     = 200;
  localparam int DEPTH  = 8;
  localparam int ERRMAX = 7;

  logic       clk, reset, ps2_clk, ps2_data;
  logic       evt_valid, evt_ready, evt_ext, evt_brk, overflow, ovf_clr, frame_err;
  logic [7:0] evt_code;
  logic [3:0] fifo_level;
  logic [2:0] err_cnt;

  ps2_kbd_event_rx #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TO), .ERR_W(3)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .fifo_level(fifo_level),
    .overflow(overflow), .ovf_clr(ovf_clr), .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  int  checks = 0, failures = 0;
  int  exp_err = 0, pulse_cnt = 0, pulse_base = 0;
  bit  m_ext = 0, m_brk = 0, ovf_exp = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] c, input int kind);
    logic p;
    p = ~^c;
    if (kind == 2) p = ~p;
    return {(kind == 3) ? 1'b0 : 1'b1, p, c, (kind == 1) ? 1'b1 : 1'b0};
  endfunction

  // Reference behaviour of one completed frame: validity, prefix folding, FIFO capacity.
  task automatic model_frame(input logic [10:0] bits);
    logic [7:0] c;
    bit ok;
    c  = bits[8:1];
    ok = (bits[0] == 1'b0) && (bits[10] == 1'b1) && ((^c ^ bits[9]) == 1'b1);
    if (!ok) begin
      exp_err++;
    end else if (c == 8'hE0) begin
      if (!m_ext && !m_brk) m_ext = 1;
    end else if (c == 8'hF0) begin
      if (!m_brk) m_brk = 1;
    end else begin
      if (exp_q.size() < DEPTH || evt_ready) exp_q.push_back({m_ext, m_brk, c});
      else ovf_exp = 1;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n,
                           input bit pop_at_push, input bit lat_chk);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) tick;
      ps2_clk = 1'b0;
      if (i == 10) begin
        // 3 sync stages + edge detect + decoder register: push cycle.
        repeat (4) tick;
        if (lat_chk) check("valid_before_push", evt_valid, 0);
        if (pop_at_push) evt_ready = 1'b1;
        model_frame(bits);
        tick;
        if (lat_chk) check("valid_latency", evt_valid, 1);
        if (pop_at_push) evt_ready = 1'b0;
      end
      repeat (HALF) tick;
      ps2_clk = 1'b1;
    end
    repeat (HALF) tick;
  endtask

  task automatic send_frame(input logic [7:0] c, input int kind);
    send_bits(make_frame(c, kind), 11, 1'b0, 1'b0);
  endtask

  task automatic check_errs;
    check("err_pulses", pulse_cnt - pulse_base, exp_err);
    check("err_cnt", int'(err_cnt), (exp_err > ERRMAX) ? ERRMAX : exp_err);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (3) tick;
    exp_q.delete();
    m_ext = 0; m_brk = 0; ovf_exp = 0; exp_err = 0;
    pulse_base = pulse_cnt;
    check("rst_valid", evt_valid, 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    reset = 1'b0;
    tick;
  endtask

  task automatic drain;
    int n;
    n = 0;
    evt_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      tick;
      n++;
    end
    check("drain_in_time", int'(exp_q.size()), 0);
    tick;
    check("level_after_drain", int'(fifo_level), 0);
  endtask

  // Monitor: compares every accepted event with the scoreboard head.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frame_err) pulse_cnt++;
        if (evt_valid && evt_ready) begin
          check("event_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event", int'({evt_ext, evt_brk, evt_code}), int'(e));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] c;
    int k;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) tick;
    do_reset;

    send_bits(make_frame(8'h1C, 0), 11, 1'b0, 1'b1);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    send_frame(8'h1C, 2);
    send_frame(8'h32, 0);
    check_errs;

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 99);
      if (k < 20)      c = 8'hE0;
      else if (k < 35) c = 8'hF0;
      else             c = 8'($urandom);
      k = $urandom_range(0, 99);
      send_frame(c, (k < 85) ? 0 : $urandom_range(1, 3));
    end
    check_errs;

    send_frame(8'h11, 0);
    send_frame(8'hE0, 0);
    send_bits(make_frame(8'h55, 0), 4, 1'b0, 1'b0);
    repeat (TO + 20) tick;
    exp_err++;
    check_errs;
    send_frame(8'h2A, 0);

    for (int i = 0; i < 9; i++) send_frame(8'($urandom), $urandom_range(1, 3));
    check_errs;
    drain;

    send_bits(make_frame(8'h66, 0), 5, 1'b0, 1'b0);
    do_reset;
    repeat (TO + 20) tick;
    check_errs;

    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      do c = 8'($urandom); while (c == 8'hE0 || c == 8'hF0);
      send_frame(c, 0);
    end
    check("full_level", int'(fifo_level), DEPTH);
    check("overflow_set", overflow, int'(ovf_exp));
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    ovf_exp = 0;
    check("overflow_clr", overflow, 0);
    send_bits(make_frame(8'h4B, 0), 11, 1'b1, 1'b0);
    check("full_pushpop_level", int'(fifo_level), DEPTH);
    check("full_pushpop_ovf", overflow, int'(ovf_exp));
    drain;
    check_errs;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/ps2_kbd_event_rx.md
PS2_KBD_EVENT_RX -- requirements
Module: ps2_kbd_event_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 3, ps2_clk/ps2_data synchroniser depth (2..4).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-004 SHALL have parameter ERR_W, default 8, width of the error counter.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ps2_clk  input  1  asynchronous PS/2 clock from the keyboard.
REQ-008 ps2_data  input  1  asynchronous PS/2 data from the keyboard.
REQ-009 evt_valid  output  1  head-of-FIFO event available.
REQ-010 evt_ready  input  1  consumer accepts the event; a pop occurs when evt_valid and evt_ready are both high.
REQ-011 evt_code  output  8  scan code of the head event.
REQ-012 evt_ext  output  1  head event was preceded by prefix 0xE0.
REQ-013 evt_brk  output  1  head event is a release (preceded by 0xF0).
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
REQ-015 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-016 ovf_clr  input  1  clears overflow.
REQ-017 frame_err  output  1  one-cycle pulse on a rejected frame (start, stop, parity or timeout).
REQ-018 err_cnt  output  ERR_W  saturating count of frame_err pulses.

Function
REQ-019 ps2_clk and ps2_data SHALL each pass through a SYNC_STAGES flop chain; sample strobe = previous synchronised ps2_clk high AND current synchronised ps2_clk low.
REQ-020 On each strobe the receiver SHALL capture the synchronised ps2_data into bit position bit_cnt (0..10), LSB-first: start, D0..D7, parity, stop.
REQ-021 On the strobe capturing bit 10 the frame SHALL be accepted only if start=0, stop=1 and XOR(D0..D7, parity)=1; otherwise frame_err pulses on the next cycle; bit_cnt returns to 0 in either case.
REQ-022 Decoder states: IDLE, EXT (0xE0 seen), BRK (0xF0 seen), EXT_BRK (0xE0 then 0xF0 seen).
REQ-023 Accepted 0xE0: IDLE->EXT; in any other state it is ignored and the state is held.
REQ-024 Accepted 0xF0: IDLE->BRK, EXT->EXT_BRK; in BRK or EXT_BRK it is ignored and the state is held.
REQ-025 Any other accepted code SHALL push {ext, brk, code} derived from the current state and return the decoder to IDLE.
REQ-026 A push SHALL reach the FIFO on the cycle after the stop-bit strobe; with the FIFO previously empty, evt_valid SHALL rise 2 cycles after the stop-bit strobe.
REQ-027 The FIFO SHALL be show-ahead: evt_code, evt_ext and evt_brk are valid whenever evt_valid=1 and hold stable until popped.
REQ-028 Push while full with no pop SHALL drop the event and set overflow; push and pop in the same cycle while full SHALL both succeed, leaving the level unchanged and overflow unchanged.
REQ-029 Pop while empty SHALL have no effect; fifo_level never wraps.
REQ-030 ovf_clr SHALL clear overflow; if ovf_clr and a new drop occur in the same cycle, overflow SHALL be 1.
REQ-031 While bit_cnt≠0, a counter SHALL count cycles since the last strobe; on reaching TIMEOUT_CYCLES the frame SHALL be discarded, bit_cnt set to 0 and frame_err pulsed; the decoder state is unchanged.
REQ-032 Rejected or timed-out frames SHALL NOT alter decoder state or FIFO contents.
REQ-033 err_cnt SHALL increment on each frame_err pulse and saturate at 2^ERR_W-1.

Reset
REQ-034 reset=1 SHALL set, on the next rising edge: bit_cnt=0, decoder=IDLE, FIFO empty, evt_valid=0, fifo_level=0, overflow=0, frame_err=0, err_cnt=0, timeout counter=0; synchroniser flops reset to 1 (idle bus).
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; no event or error is produced from bits received before reset.

Verification
REQ-036 Frame 0x1C, good parity, evt_ready=1 -> one event code=0x1C ext=0 brk=0; evt_valid high 2 cycles after the stop strobe.
REQ-037 Frames E0,F0,75 -> single event code=0x75 ext=1 brk=1; decoder back in IDLE.
REQ-038 Frame 0x1C with parity bit inverted -> no event, frame_err one pulse, err_cnt=1; following good frame 0x32 -> event 0x32.
REQ-039 evt_ready=0, FIFO_DEPTH=8, send 9 make codes -> fifo_level=8, overflow=1, first 8 codes popped in order; ovf_clr -> overflow=0.
REQ-040 Send 4 bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulse, bit_cnt=0; next full frame 0x2A decoded correctly.
REQ-041 FIFO full, evt_ready=1 on the same cycle as a push -> level stays 8, overflow stays 0, new code appears at the tail.
